// File: rtl/add4_chk_pkg.sv
// Shared types and widths for the 4-bit adder sweep checker.
package add4_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int VEC_W = 9;
    localparam int RES_W = 5;
    localparam int ERR_W = 10;

    localparam logic [VEC_W-1:0] LAST_IDX = 9'd511;

endpackage

// File: rtl/add_4_ref.sv
// Combinational golden model of a 4-bit adder: sum_o = {CO,S}.
module add_4_ref
    import add4_chk_pkg::*;
(
    input  logic [3:0]       a_i,
    input  logic [3:0]       b_i,
    input  logic             ci_i,
    output logic [RES_W-1:0] sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, ci_i};

endmodule

// File: rtl/add_4_checker.sv
// Exhaustive 512-vector sweep checker for a 4-bit adder under test.
// Optional first-failure capture is built when ADD4_CHK_CAPTURE_EN is defined.
module add_4_checker
    import add4_chk_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic             CI,
    input  logic [3:0]       S,
    input  logic             CO,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] fail_vec,
    output logic [RES_W-1:0] fail_obs
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    state_e            state_q, state_d;
    logic [VEC_W-1:0]  idx_q, idx_d;
    logic [3:0]        settle_q, settle_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [RES_W-1:0]  exp_res;
    logic              start_acc;
    logic              mismatch;

    add_4_ref u_ref (
        .a_i   (idx_q[3:0]),
        .b_i   (idx_q[7:4]),
        .ci_i  (idx_q[8]),
        .sum_o (exp_res)
    );

    // The operand registers are the vector index itself, so A/B/CI hold 511 in DONE.
    assign A  = idx_q[3:0];
    assign B  = idx_q[7:4];
    assign CI = idx_q[8];

    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    assign mismatch  = (state_q == CHECK) && ({CO, S} != exp_res);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = SETTLE;
            SETTLE:     if (settle_q == 4'd1) state_d = CHECK;
            CHECK:      state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SETTLE) || (state_q == CHECK);
        done = (state_q == DONE);
        pass = (state_q == DONE) && (err_q == '0);
    end

    always_comb begin
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        if (start_acc) begin
            idx_d    = '0;
            err_d    = '0;
            settle_d = SETTLE_LD;
        end else if (state_q == SETTLE) begin
            settle_d = settle_q - 4'd1;
        end else if (state_q == CHECK) begin
            if (mismatch) err_d = err_q + 10'd1;
            if (idx_q != LAST_IDX) begin
                idx_d    = idx_q + 9'd1;
                settle_d = SETTLE_LD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
        end
    end

    assign err_count = err_q;

`ifdef ADD4_CHK_CAPTURE_EN
    logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
    logic [RES_W-1:0] fail_obs_q, fail_obs_d;

    // err_q is still zero during the CHECK of the first failing vector.
    always_comb begin
        fail_vec_d = fail_vec_q;
        fail_obs_d = fail_obs_q;
        if (start_acc) begin
            fail_vec_d = '0;
            fail_obs_d = '0;
        end else if (mismatch && (err_q == '0)) begin
            fail_vec_d = idx_q;
            fail_obs_d = {CO, S};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec_q <= '0;
            fail_obs_q <= '0;
        end else begin
            fail_vec_q <= fail_vec_d;
            fail_obs_q <= fail_obs_d;
        end
    end

    assign fail_vec = fail_vec_q;
    assign fail_obs = fail_obs_q;
`else
    assign fail_vec = '0;
    assign fail_obs = '0;
`endif

endmodule

// File: tb/tb_add_4_checker.sv
// Bench for add_4_checker: two instances (settle 1 and 3) driving a fault-injectable adder.
module tb_add_4_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;

    logic [3:0] A1, B1, S1, A3, B3, S3;
    logic       CI1, CO1, CI3, CO3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [9:0] err1, err3;
    logic [8:0] fv1, fv3;
    logic [4:0] fo1, fo3;

    // Fault description for the adder under test
    int         fmode = 0;   // 0 good, 1 CO stuck 0, 2 result bit fbit stuck at fval, 3 xor on one vector
    int         fbit  = 0;
    int         fval  = 0;
    logic [8:0] fidx  = '0;
    logic [4:0] fxor  = '0;

    int vectors = 0;
    int miscompares = 0;

    logic       sel = 1'b0;
    logic [8:0] o_drv;
    logic       o_busy, o_done, o_pass;
    logic [9:0] o_err;
    logic [8:0] o_fv;
    logic [4:0] o_fo;

    always #5 clk = ~clk;

    add_4_checker #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .A(A1), .B(B1), .CI(CI1), .S(S1), .CO(CO1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1), .fail_obs(fo1)
    );

    add_4_checker #(.SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .A(A3), .B(B3), .CI(CI3), .S(S3), .CO(CO3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_vec(fv3), .fail_obs(fo3)
    );

    logic [4:0] r1, r3;
    always_comb begin
        r1 = {1'b0, A1} + {1'b0, B1} + {4'b0000, CI1};
        r3 = {1'b0, A3} + {1'b0, B3} + {4'b0000, CI3};
        case (fmode)
            1: begin r1[4] = 1'b0; r3[4] = 1'b0; end
            2: begin r1[fbit] = fval[0]; r3[fbit] = fval[0]; end
            3: begin
                if ({CI1, B1, A1} == fidx) r1 = r1 ^ fxor;
                if ({CI3, B3, A3} == fidx) r3 = r3 ^ fxor;
            end
            default: ;
        endcase
        S1 = r1[3:0]; CO1 = r1[4];
        S3 = r3[3:0]; CO3 = r3[4];
    end

    assign o_drv  = sel ? {CI3, B3, A3} : {CI1, B1, A1};
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_pass = sel ? pass3 : pass1;
    assign o_err  = sel ? err3  : err1;
    assign o_fv   = sel ? fv3   : fv1;
    assign o_fo   = sel ? fo3   : fo1;

    // Reference: walk all 512 vectors arithmetically under the current fault description.
    task automatic model(output int e, output logic [8:0] fv, output logic [4:0] fo);
        int a, b, c, good, obs;
        e = 0; fv = '0; fo = '0;
        for (int i = 0; i < 512; i++) begin
            a = i % 16; b = (i / 16) % 16; c = i / 256;
            good = a + b + c;
            obs  = good;
            if (fmode == 1) obs = good % 16;
            else if (fmode == 2) obs = (fval != 0) ? (good | (1 << fbit)) : (good & ~(1 << fbit));
            else if (fmode == 3 && i == int'(fidx)) obs = good ^ int'(fxor);
            if (obs != good) begin
                if (e == 0) begin fv = 9'(i); fo = 5'(obs); end
                e++;
            end
        end
    endtask

    task automatic set_start(input logic s, input logic v);
        if (s) start3 = v; else start1 = v;
    endtask

    task automatic run_sweep(input logic s, input int settle, input int restart_at, input string tag);
        int         e, n, total, drv_bad, expv;
        logic [8:0] mfv, efv;
        logic [4:0] mfo, efo;
        sel = s;
        model(e, mfv, mfo);
`ifdef ADD4_CHK_CAPTURE_EN
        efv = mfv; efo = mfo;
`else
        efv = '0; efo = '0;
`endif
        total = 512 * (settle + 1);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        @(negedge clk); set_start(s, 1'b1);
        @(posedge clk);
        n = 0; drv_bad = 0;
        @(negedge clk); set_start(s, 1'b0);
        forever begin
            expv = n / (settle + 1);
            if (expv > 511) expv = 511;
            if (o_drv !== 9'(expv) || o_busy !== (n < total)) drv_bad++;
            if (o_done === 1'b1 || n > total + 20) break;
            set_start(s, n == restart_at);
            @(posedge clk); n++;
            @(negedge clk);
        end
        set_start(s, 1'b0);
        vectors++;
        if (drv_bad !== 0) begin miscompares++; $display("FAIL %s drive/busy sequence: %0d bad cycles, required 0", tag, drv_bad); end
        vectors++;
        if (n !== total) begin miscompares++; $display("FAIL %s done edge: got %0d required %0d", tag, n, total); end
        vectors++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin miscompares++; $display("FAIL %s done/busy: got %b/%b required 1/0", tag, o_done, o_busy); end
        vectors++;
        if (o_err !== 10'(e)) begin miscompares++; $display("FAIL %s err_count: got %0d required %0d", tag, o_err, e); end
        vectors++;
        if (o_pass !== (e == 0)) begin miscompares++; $display("FAIL %s pass: got %b required %b", tag, o_pass, (e == 0)); end
        vectors++;
        if (o_fv !== efv || o_fo !== efo) begin miscompares++; $display("FAIL %s capture: got %h/%h required %h/%h", tag, o_fv, o_fo, efv, efo); end
        repeat (3) @(negedge clk);
        vectors++;
        if (o_done !== 1'b1 || o_drv !== 9'd511 || o_err !== 10'(e)) begin
            miscompares++;
            $display("FAIL %s hold in done: done=%b drv=%0d err=%0d required 1/511/%0d", tag, o_done, o_drv, o_err, e);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            vectors++;
            if ({o_drv, o_busy, o_done, o_pass, o_err, o_fv, o_fo} !== 37'd0) begin
                miscompares++;
                $display("FAIL reset_vals dut%0d: got %h required 0", k, {o_drv, o_busy, o_done, o_pass, o_err, o_fv, o_fo});
            end
        end
    endtask

    task automatic test_good_sweep();
        fmode = 0;
        run_sweep(1'b0, 1, -1, "good_s1");
    endtask

    task automatic test_co_stuck();
        fmode = 1;
        run_sweep(1'b0, 1, -1, "co_stuck");
        vectors++;
        if (o_err !== 10'd256 || o_pass !== 1'b0) begin miscompares++; $display("FAIL co_stuck_const: err=%0d pass=%b required 256/0", o_err, o_pass); end
`ifdef ADD4_CHK_CAPTURE_EN
        vectors++;
        if (o_fv !== 9'd31 || o_fo !== 5'b00000) begin miscompares++; $display("FAIL co_stuck_capture: got %h/%h required 01f/00", o_fv, o_fo); end
`else
        vectors++;
        if (o_fv !== 9'd0 || o_fo !== 5'd0) begin miscompares++; $display("FAIL co_stuck_tied: got %h/%h required 0/0", o_fv, o_fo); end
`endif
    endtask

    task automatic test_s0_stuck();
        fmode = 2; fbit = 0; fval = 1;
        run_sweep(1'b0, 1, -1, "s0_stuck");
        vectors++;
        if (o_err !== 10'd256) begin miscompares++; $display("FAIL s0_stuck_const: err=%0d required 256", o_err); end
`ifdef ADD4_CHK_CAPTURE_EN
        vectors++;
        if (o_fv !== 9'd0 || o_fo !== 5'b00001) begin miscompares++; $display("FAIL s0_stuck_capture: got %h/%h required 000/01", o_fv, o_fo); end
`endif
    endtask

    task automatic test_settle3();
        fmode = 0;
        run_sweep(1'b1, 3, -1, "good_s3");
    endtask

    task automatic test_restart_busy();
        fmode = 0;
        run_sweep(1'b0, 1, 100, "restart_busy");
    endtask

    task automatic test_reset_mid();
        int n;
        fmode = 1; sel = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (n = 1; n < 300; n++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_drv, o_busy, o_done, o_pass, o_err, o_fv, o_fo} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %h required 0", {o_drv, o_busy, o_done, o_pass, o_err, o_fv, o_fo});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if ({o_drv, o_busy, o_done, o_pass, o_err, o_fv, o_fo} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_mid_idle: got %h required 0", {o_drv, o_busy, o_done, o_pass, o_err, o_fv, o_fo});
        end
        fmode = 0;
        run_sweep(1'b0, 1, -1, "after_reset");
    endtask

    task automatic test_random();
        logic s;
        for (int it = 0; it < 6; it++) begin
            fmode = $urandom_range(0, 3);
            fbit  = $urandom_range(0, 4);
            fval  = $urandom_range(0, 1);
            fidx  = 9'($urandom_range(0, 511));
            fxor  = 5'($urandom_range(1, 31));
            s     = 1'($urandom_range(0, 1));
            run_sweep(s, s ? 3 : 1, (it % 2 == 0) ? int'($urandom_range(5, 400)) : -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_co_stuck();
        test_s0_stuck();
        test_settle3();
        test_restart_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/add_4_checker.md
# add_4_checker

Self-checking response block for the 4-bit ripple adder interface (A, B, CI → S, CO). It generates every one of the 512 operand combinations and drives them into an adder under test. It samples the adder's sum and carry after a programmable settle time and compares them against an internal reference. It then reports pass/fail, an error count and, optionally, the first failing vector, so adder hardware can be checked on-board without a simulator.

## Interface
- SETTLE_CYC, default 1: cycles between driving a vector and sampling the response; legal range 1..15.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a full sweep.
- A  out  4  operand A to the adder under test (registered).
- B  out  4  operand B to the adder under test (registered).
- CI  out  1  carry-in to the adder under test (registered).
- S  in  4  sum from the adder under test.
- CO  in  1  carry-out from the adder under test.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next accepted start.
- pass  out  1  valid while done=1; 1 iff err_count==0.
- err_count  out  10  number of mismatching vectors; maximum is 512, so it never saturates.
- fail_vec  out  9  {CI,B,A} of the first mismatch.
- fail_obs  out  5  {CO,S} observed at the first mismatch.

## Operation
- Vector index idx[8:0] maps as A=idx[3:0], B=idx[7:4], CI=idx[8]; the sweep runs idx 0→511 in order.
- Expected result is the 5-bit sum {1'b0,A}+{1'b0,B}+CI, compared against {CO,S}.
- FSM states:
  - IDLE: on start=1, set idx←0, clear err_count and the fail capture, drive vector 0, load settle_cnt←SETTLE_CYC, go to SETTLE.
  - SETTLE: decrement settle_cnt; when settle_cnt==1, go to CHECK.
  - CHECK: compare; on mismatch, err_count+1 and capture if this is the first mismatch. If idx==511, go to DONE; otherwise idx+1, drive the next vector, reload settle_cnt, go to SETTLE.
  - DONE: done=1 and pass valid. start=1 behaves exactly as in IDLE.
- busy=1 in SETTLE and CHECK only.
- start is ignored while busy=1.
- A/B/CI hold their last value in DONE.
- Reset values: A=0, B=0, CI=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_obs=0; state=IDLE.
- Reset mid-sweep aborts immediately to the reset values. No partial result is retained.

## Timing
- Each vector occupies SETTLE_CYC+1 cycles: SETTLE_CYC cycles in SETTLE, then 1 cycle in CHECK.
- S/CO are sampled at the clock edge that ends CHECK, at least SETTLE_CYC cycles after the operands changed.
- If start is sampled high at edge 0, done rises after edge 512·(SETTLE_CYC+1); with the default this is edge 1024.
- busy falls on the same edge that done rises.
- err_count updates on the edge ending each CHECK.
- The fail capture is written only on the first mismatch of a sweep.

## Configuration
- ADD4_CHK_CAPTURE_EN defined: fail_vec and fail_obs capture the first mismatch as described.
- ADD4_CHK_CAPTURE_EN undefined: the capture registers are not built, and fail_vec and fail_obs are tied to 0. All other behaviour is identical.

## Structure
- Package add4_chk_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - VEC_W=9, RES_W=5, ERR_W=10;
  - LAST_IDX=9'd511.
- Sub-module add_4_ref: a combinational reference model producing the expected 5-bit {CO,S} from A, B, CI, instantiated once inside the checker.

## Test plan
- Correct adder attached, SETTLE_CYC=1, pulse start → done at cycle 1024, pass=1, err_count=0, fail_vec=0.
- CO stuck at 0 → err_count=256, pass=0, fail_vec={0,4'd1,4'd15} (idx 31), fail_obs=5'b00000.
- S[0] stuck at 1 → err_count=256, fail_vec=0 (A=0,B=0,CI=0), fail_obs=5'b00001.
- SETTLE_CYC=3, correct adder → done at cycle 2048, pass=1; the A/B/CI drive changes every 4 cycles.
- start re-pulsed at cycle 100 while busy → ignored, done still at cycle 1024.
- rst_n pulsed low at cycle 300 → all outputs return to their reset values immediately and the block stays in IDLE until the next start. The following sweep then completes normally.
- ADD4_CHK_CAPTURE_EN undefined, CO stuck at 0 → err_count=256 and fail_vec/fail_obs=0.
